// File: rtl/util_win_ctrl.sv
// -----------------------------------------------------------------------------
// util_win_ctrl
//
// Window controller and result collector for the CA utilization monitor.
// A free-running window of 2^WIN_SHIFT cycles is framed by a one-cycle
// mon_upd pulse. Each pulse closes the monitor's window and clears its
// counters. The monitor then presents its eight utilization fields for one
// cycle. This block captures them as a stable snapshot. It also maintains:
//   - per-field peaks,
//   - a clamped total-busy percentage,
//   - a count of completed windows.
//
// Optional feature (compile-time macro UTIL_ALARM_EN):
//   When defined, a sticky alarm is raised after ALARM_WIN consecutive
//   reported windows whose busy_pct is at or above alarm_thr.
//   When undefined, util_alarm is tied low and alarm_thr is ignored.
//
// Ports:
//   clk          core clock
//   rst          synchronous, active-high reset
//   mon_en       level; 1 = windows run, 0 = idle
//   mon_upd      registered one-cycle pulse to the monitor (closes a window)
//   aimc_ca_util NCH x UW utilization fields from the monitor
//   peak_clr     one-cycle pulse; clears util_peak (and util_alarm)
//   util_vld     one-cycle pulse; util_snap / busy_pct just updated
//   util_snap    last captured window values
//   util_peak    per-field maximum since reset or peak_clr
//   busy_pct     sum of fields NCH-1..2 of the snapshot, clamped to 100
//   win_cnt      completed (reported) windows, wraps at 16 bits
//   alarm_thr    alarm threshold in percent
//   util_alarm   sticky utilization alarm
// -----------------------------------------------------------------------------
module util_win_ctrl #(
  parameter int WIN_SHIFT = 24,
  parameter int UW        = 6,
  parameter int NCH       = 8,
  parameter int ALARM_WIN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mon_en,
  output logic                    mon_upd,
  input  logic [NCH-1:0][UW-1:0]  aimc_ca_util,
  input  logic                    peak_clr,
  output logic                    util_vld,
  output logic [NCH-1:0][UW-1:0]  util_snap,
  output logic [NCH-1:0][UW-1:0]  util_peak,
  output logic [6:0]              busy_pct,
  output logic [15:0]             win_cnt,
  input  logic [6:0]              alarm_thr,
  output logic                    util_alarm
);

  // A zero-length window would need back-to-back captures with no gap
  // between the close pulse and the capture; not supported.
  if (WIN_SHIFT < 1) begin : g_bad_win_shift
    $error("util_win_ctrl: WIN_SHIFT must be >= 1");
  end
  if (ALARM_WIN < 1 || ALARM_WIN > 7) begin : g_bad_alarm_win
    $error("util_win_ctrl: ALARM_WIN must be in 1..7 (3-bit run counter)");
  end

  localparam logic [WIN_SHIFT-1:0] T_LAST = '1;
  // mon_upd is registered, so it is set one count before the terminal value
  // and is high while the timer reads T_LAST.
  localparam logic [WIN_SHIFT-1:0] T_PRE  = T_LAST - WIN_SHIFT'(1);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Sum of the reported fields (NCH-1..2), 9 bits wide.
  function automatic logic [8:0] field_sum(input logic [NCH-1:0][UW-1:0] f);
    logic [8:0] s;
    s = '0;
    for (int i = 2; i < NCH; i++) begin
      s = s + 9'(f[i]);
    end
    return s;
  endfunction

  // Saturate a sum to a percentage.
  function automatic logic [6:0] sat_pct(input logic [8:0] s);
    return (s > 9'd100) ? 7'd100 : s[6:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Window FSM, timer and mon_upd
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e               state_q;
  logic [WIN_SHIFT-1:0] timer_q;
  logic                 mon_upd_q;
  // Tags the current mon_upd as the prime pulse, whose partial window is
  // thrown away instead of reported.
  logic                 upd_disc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      mon_upd_q  <= 1'b0;
      upd_disc_q <= 1'b0;
    end else begin
      mon_upd_q  <= 1'b0;
      upd_disc_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (mon_en) begin
            // The pulse is high during the PRIME cycle itself.
            state_q    <= S_PRIME;
            mon_upd_q  <= 1'b1;
            upd_disc_q <= 1'b1;
          end
        end
        S_PRIME: begin
          timer_q <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (!mon_en) begin
            // Leave without closing the window, even at terminal count.
            state_q <= S_IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + WIN_SHIFT'(1);
            if (timer_q == T_PRE) begin
              mon_upd_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign mon_upd = mon_upd_q;

  // ---------------------------------------------------------------------------
  // Stage p0: monitor fields valid this cycle (one after mon_upd)
  // ---------------------------------------------------------------------------
  logic vld_p0_q;
  logic disc_p0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q  <= 1'b0;
      disc_p0_q <= 1'b0;
    end else begin
      vld_p0_q  <= mon_upd_q;
      disc_p0_q <= upd_disc_q;
    end
  end

  logic       cap_rpt;
  logic [6:0] cap_busy;

  assign cap_rpt  = vld_p0_q && !disc_p0_q;
  assign cap_busy = sat_pct(field_sum(aimc_ca_util));

  // ---------------------------------------------------------------------------
  // Stage p1: snapshot, peaks, busy and count registered; util_vld pulses
  // ---------------------------------------------------------------------------
  logic                   vld_p1_q;
  logic [NCH-1:0][UW-1:0] snap_q,  snap_d;
  logic [NCH-1:0][UW-1:0] peak_q,  peak_d;
  logic [6:0]             busy_q,  busy_d;
  logic [15:0]            cnt_q,   cnt_d;

  always_comb begin
    snap_d = snap_q;
    peak_d = peak_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (cap_rpt) begin
      snap_d = aimc_ca_util;
      busy_d = cap_busy;
      cnt_d  = cnt_q + 16'd1;
      // A coincident peak_clr clears first, so the peak reloads from the
      // new snapshot.
      for (int i = 0; i < NCH; i++) begin
        if (peak_clr || (aimc_ca_util[i] > peak_q[i])) begin
          peak_d[i] = aimc_ca_util[i];
        end
      end
    end else if (peak_clr) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      snap_q   <= '0;
      peak_q   <= '0;
      busy_q   <= '0;
      cnt_q    <= '0;
    end else begin
      vld_p1_q <= cap_rpt;
      snap_q   <= snap_d;
      peak_q   <= peak_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign util_vld  = vld_p1_q;
  assign util_snap = snap_q;
  assign util_peak = peak_q;
  assign busy_pct  = busy_q;
  assign win_cnt   = cnt_q;

`ifdef UTIL_ALARM_EN
  // Consecutive over-threshold run length, saturating at ALARM_WIN.
  logic [2:0] run_q, run_d;
  logic       alarm_q, alarm_d;

  always_comb begin
    run_d   = run_q;
    alarm_d = alarm_q && !peak_clr;
    if (cap_rpt) begin
      if (cap_busy >= alarm_thr) begin
        if (run_q < 3'(ALARM_WIN)) begin
          run_d = run_q + 3'd1;
        end
        // Setting overrides a coincident peak_clr.
        if (run_q >= 3'(ALARM_WIN - 1)) begin
          alarm_d = 1'b1;
        end
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      alarm_q <= alarm_d;
    end
  end

  assign util_alarm = alarm_q;
`else
  logic unused_alarm_thr;
  assign unused_alarm_thr = ^alarm_thr;
  assign util_alarm       = 1'b0;
`endif

endmodule

// File: tb/tb_util_win_ctrl.sv
module tb_util_win_ctrl;

  localparam int WS   = 4;
  localparam int WIN  = 1 << WS;
  localparam int AWIN = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mon_en = 1'b0;
  logic            mon_upd;
  logic [7:0][5:0] aimc = '0;
  logic            peak_clr = 1'b0;
  logic            util_vld;
  logic [7:0][5:0] util_snap;
  logic [7:0][5:0] util_peak;
  logic [6:0]      busy_pct;
  logic [15:0]     win_cnt;
  logic [6:0]      alarm_thr = 7'd50;
  logic            util_alarm;

  util_win_ctrl #(.WIN_SHIFT(WS), .UW(6), .NCH(8), .ALARM_WIN(AWIN)) dut (
    .clk(clk), .rst(rst), .mon_en(mon_en), .mon_upd(mon_upd),
    .aimc_ca_util(aimc), .peak_clr(peak_clr), .util_vld(util_vld),
    .util_snap(util_snap), .util_peak(util_peak), .busy_pct(busy_pct),
    .win_cnt(win_cnt), .alarm_thr(alarm_thr), .util_alarm(util_alarm)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = -1;
  int upd_log[$];
  int vld_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: windows described by "age" = cycles since the prime
  // pulse; a close happens whenever age is a multiple of the window length.
  // ---------------------------------------------------------------------------
  int              m_age = -1;
  bit              m_pend = 1'b0;
  bit              m_upd = 1'b0;
  bit              m_vld = 1'b0;
  logic [7:0][5:0] m_snap = '0;
  logic [7:0][5:0] m_peak = '0;
  int              m_busy = 0;
  int              m_cnt = 0;
  int              m_run = 0;
  bit              m_alarm = 1'b0;
  int              m_sum;

  always @(posedge clk) begin
    if (rst) begin
      m_age = -1; m_pend = 0; m_upd = 0; m_vld = 0;
      m_snap = '0; m_peak = '0; m_busy = 0; m_cnt = 0; m_run = 0; m_alarm = 0;
    end else begin
      m_vld = m_pend;
      if (m_pend) begin
        m_sum = 0;
        for (int i = 0; i < 8; i++) begin
          m_snap[i] = aimc[i];
          if (i >= 2) m_sum = m_sum + int'(aimc[i]);
          if (peak_clr || aimc[i] > m_peak[i]) m_peak[i] = aimc[i];
        end
        m_busy = (m_sum > 100) ? 100 : m_sum;
        m_cnt  = (m_cnt + 1) % 65536;
      end else if (peak_clr) begin
        m_peak = '0;
      end
`ifdef UTIL_ALARM_EN
      if (peak_clr) m_alarm = 0;
      if (m_pend) begin
        if (m_busy >= int'(alarm_thr)) begin
          if (m_run < AWIN) m_run++;
          if (m_run >= AWIN) m_alarm = 1;
        end else begin
          m_run = 0;
        end
      end
`endif
      m_pend = m_upd && (m_age > 0);
      if (m_age < 0) begin
        if (mon_en) m_age = 0;
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (!mon_en) begin
        m_age = -1;
      end else begin
        m_age++;
      end
      m_upd = (m_age >= 0) && (m_age % WIN == 0);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc >= 0) begin
      chk("mon_upd",    64'(mon_upd),    64'(m_upd));
      chk("util_vld",   64'(util_vld),   64'(m_vld));
      chk("util_snap",  64'(util_snap),  64'(m_snap));
      chk("util_peak",  64'(util_peak),  64'(m_peak));
      chk("busy_pct",   64'(busy_pct),   64'(m_busy));
      chk("win_cnt",    64'(win_cnt),    64'(m_cnt));
      chk("util_alarm", 64'(util_alarm), 64'(m_alarm));
      if (mon_upd === 1'b1) upd_log.push_back(cyc);
      if (util_vld === 1'b1) vld_log.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  logic [7:0][5:0] x;
  int c0;
  int bseq[7] = '{60, 60, 40, 60, 60, 60, 60};
  int exp_upd[4] = '{11, 27, 43, 59};
  int exp_vld[3] = '{29, 45, 61};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    goto(2);
    chk("rst_win_cnt", 64'(win_cnt), 64'd0);
    chk("rst_vld", 64'(util_vld), 64'd0);
    rst = 1'b0;
    goto(10);
    mon_en = 1'b1;

    goto(28);
    aimc[7] = 6'd40; aimc[6] = 6'd30; aimc[5] = 6'd20; aimc[2] = 6'd15;
    goto(29);
    aimc = '0;
    x = '0; x[7] = 6'd40; x[6] = 6'd30; x[5] = 6'd20; x[2] = 6'd15;
    chk("lit_vld29", 64'(util_vld), 64'd1);
    chk("lit_snap1", 64'(util_snap), 64'(x));
    chk("lit_busy1", 64'(busy_pct), 64'd100);
    chk("lit_peak1", 64'(util_peak), 64'(x));

    goto(44);
    aimc[7] = 6'd10;
    goto(45);
    aimc = '0;
    chk("lit_snap2_f7", 64'(util_snap[7]), 64'd10);
    chk("lit_busy2", 64'(busy_pct), 64'd10);
    chk("lit_peak2", 64'(util_peak), 64'(x));

    goto(60);
    aimc[7] = 6'd7; aimc[3] = 6'd5; peak_clr = 1'b1;
    goto(61);
    aimc = '0; peak_clr = 1'b0;
    x = '0; x[7] = 6'd7; x[3] = 6'd5;
    chk("lit_peakclr", 64'(util_peak), 64'(x));
    chk("lit_busy3", 64'(busy_pct), 64'd12);

    goto(62);
    chk("lit_win_cnt3", 64'(win_cnt), 64'd3);
    chk("n_upd", 64'(upd_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("upd_cycle", 64'((i < upd_log.size()) ? upd_log[i] : -1), 64'(exp_upd[i]));
    chk("n_vld", 64'(vld_log.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("vld_cycle", 64'((i < vld_log.size()) ? vld_log[i] : -1), 64'(exp_vld[i]));

    goto(76);
    mon_en = 1'b0;
    goto(77);
    chk("lit_vld_after_drop", 64'(util_vld), 64'd1);
    goto(85);
    chk("lit_no_upd_idle", 64'(upd_log.size()), 64'd5);
    chk("lit_win_cnt4", 64'(win_cnt), 64'd4);
    mon_en = 1'b1;
    goto(86);
    chk("lit_reprime", 64'(mon_upd), 64'd1);

    goto(103);
    rst = 1'b1;
    goto(104);
    rst = 1'b0;
    chk("lit_rst_vld", 64'(util_vld), 64'd0);
    chk("lit_rst_cnt", 64'(win_cnt), 64'd0);
    chk("lit_rst_snap", 64'(util_snap), 64'd0);
    chk("lit_rst_peak", 64'(util_peak), 64'd0);
    chk("lit_rst_busy", 64'(busy_pct), 64'd0);
    goto(106);
    chk("lit_rst_cancel", 64'(vld_log.size()), 64'd4);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      tick();
      for (int f = 0; f < 8; f++) aimc[f] = 6'($urandom_range(0, 20));
      if (mon_en) begin
        if ($urandom_range(0, 99) < 1) mon_en = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 20) mon_en = 1'b1;
      end
      peak_clr = ($urandom_range(0, 99) < 3);
      rst      = ($urandom_range(0, 999) < 3);
      if (i % 500 == 0) alarm_thr = 7'($urandom_range(30, 90));
    end

`ifdef UTIL_ALARM_EN
    tick();
    rst = 1'b1; mon_en = 1'b0; peak_clr = 1'b0; aimc = '0; alarm_thr = 7'd50;
    tick();
    tick();
    rst = 1'b0; mon_en = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 7; k++) begin
      goto(c0 + 2 + WIN * k);
      aimc[7] = 6'(bseq[k-1]);
      tick();
      aimc = '0;
      chk("alarm_busy", 64'(busy_pct), 64'(bseq[k-1]));
      chk("alarm_seq", 64'(util_alarm), 64'(k == 7));
    end
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    chk("alarm_clr", 64'(util_alarm), 64'd0);
`endif

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
